// File: rtl/dsm_mod2.sv
// Second-order single-bit delta-sigma modulator (MOD2) with saturating integrators.
// Optional dither: define DSM_DITHER_EN to add a 16-bit LFSR offset into the second integrator.
module dsm_mod2 #(
   parameter int IN_W     = 20,
   parameter int ACC_W    = 24,
   parameter int FS_SHIFT = 19
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic signed [IN_W-1:0] vin,
   output logic                   pwm
);

   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] FB_POS  = SW'(64'sd1 <<< FS_SHIFT);
   localparam logic signed [SW-1:0] ACC_MAX = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] ACC_MIN = SW'(-(64'sd1 <<< (ACC_W - 1)));

   logic signed [ACC_W-1:0] i1;
   logic signed [ACC_W-1:0] i2;
   logic signed [ACC_W-1:0] i1_next;
   logic signed [ACC_W-1:0] i2_next;
   logic signed [SW-1:0]    x;
   logic signed [SW-1:0]    fb;
   logic signed [SW-1:0]    d;
   logic signed [SW-1:0]    s1;
   logic signed [SW-1:0]    s2;

   // Clamp a wide sum into the integrator range instead of letting it wrap.
   function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] s);
      if (s > ACC_MAX)
         return ACC_MAX[ACC_W-1:0];
      else if (s < ACC_MIN)
         return ACC_MIN[ACC_W-1:0];
      else
         return s[ACC_W-1:0];
   endfunction

`ifdef DSM_DITHER_EN
   logic [15:0]       lfsr;
   logic signed [4:0] d_small;

   always_comb begin
      d_small = $signed({1'b0, lfsr[3:0]}) - 5'sd8;
      d       = SW'(d_small);
   end
`else
   always_comb d = '0;
`endif

   // The second integrator sees the freshly updated first integrator (delay-free path).
   always_comb begin
      x       = SW'(vin);
      fb      = pwm ? FB_POS : -FB_POS;
      s1      = SW'(i1) + x - fb;
      i1_next = sat(s1);
      s2      = SW'(i2) + SW'(i1_next) + d - fb;
      i2_next = sat(s2);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         i1  <= '0;
         i2  <= '0;
         pwm <= 1'b0;
      end else begin
         i1  <= i1_next;
         i2  <= i2_next;
         pwm <= ~i2_next[ACC_W-1];
      end
   end

`ifdef DSM_DITHER_EN
   always_ff @(posedge clock) begin
      if (reset)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
`endif

endmodule

// File: tb/tb_dsm_mod2.sv
// Bench for dsm_mod2: fixed vectors, density checks and a saturating arithmetic reference model.
module tb_dsm_mod2;

   logic               clock;
   logic               reset;
   logic signed [19:0] vin;
   logic               pwm;

   int checks = 0;
   int errors = 0;

   longint m_i1, m_i2;
   logic   m_pwm;
   logic [15:0] m_lfsr;

   localparam longint F    = 64'sd1 <<< 19;
   localparam longint AMAX = (64'sd1 <<< 23) - 1;
   localparam longint AMIN = -(64'sd1 <<< 23);

   dsm_mod2 dut (
      .clock (clock),
      .reset (reset),
      .vin   (vin),
      .pwm   (pwm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic longint clampv(input longint s);
      if (s > AMAX) return AMAX;
      if (s < AMIN) return AMIN;
      return s;
   endfunction

   task automatic model_step(input logic r, input logic signed [19:0] v);
      longint fbv, dv, a, b;
      if (r) begin
         m_i1 = 0; m_i2 = 0; m_pwm = 1'b0; m_lfsr = 16'hACE1;
      end else begin
         fbv = m_pwm ? F : -F;
`ifdef DSM_DITHER_EN
         dv = longint'(m_lfsr[3:0]) - 8;
`else
         dv = 0;
`endif
         a = clampv(m_i1 + longint'(v) - fbv);
         b = clampv(m_i2 + a - fbv + dv);
         m_i1 = a; m_i2 = b; m_pwm = (b >= 0);
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // One clock: drive, let the edge happen, then compare DUT against the model.
   task automatic tick(input logic r, input logic signed [19:0] v);
      reset = r;
      vin   = v;
      @(posedge clock);
      #1;
      model_step(r, v);
      chk("pwm_model", pwm, m_pwm);
      chk("i1_model", longint'(dut.i1), m_i1);
      chk("i2_model", longint'(dut.i2), m_i2);
   endtask

   typedef struct {
      logic        rst;
      logic [19:0] v;
      logic        exp_pwm;
   } vec_t;

   vec_t tbl[15];
   logic zseq[12];
   int   ones;
   int   aper;
   logic hist[4];

   initial begin
      zseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++)  tbl[i] = '{1'b1, 20'h12345, 1'b0};
      for (int i = 0; i < 12; i++) tbl[3 + i] = '{1'b0, 20'h00000, zseq[i]};

      reset = 1'b1;
      vin   = '0;
      m_i1 = 0; m_i2 = 0; m_pwm = 1'b0; m_lfsr = 16'hACE1;

      // Reset hold and zero-input start-up sequence
      for (int i = 0; i < 15; i++) begin
         tick(tbl[i].rst, tbl[i].v);
         if (tbl[i].rst) begin
            chk("reset_pwm", pwm, 0);
            chk("reset_i1", longint'(dut.i1), 0);
            chk("reset_i2", longint'(dut.i2), 0);
         end
`ifndef DSM_DITHER_EN
         else
            chk("zero_seq", pwm, tbl[i].exp_pwm);
`endif
      end

      // DC density +2^18 -> 0.75
      tick(1'b1, '0);
      ones = 0;
      for (int i = 0; i < 4096; i++) begin
         tick(1'b0, 20'sh40000);
         ones += int'(pwm);
      end
      chk_range("dc_pos_density", ones, 3032, 3112);

      // DC density -2^18 -> 0.25
      tick(1'b1, '0);
      ones = 0;
      for (int i = 0; i < 4096; i++) begin
         tick(1'b0, 20'sh80000 | 20'sh40000);
         ones += int'(pwm);
      end
      chk_range("dc_neg_density", ones, 984, 1064);

      // Random in-range stimulus with occasional reset
      tick(1'b1, '0);
      for (int i = 0; i < 3000; i++) begin
         int rv;
         rv = int'($urandom_range(838860, 0)) - 419430;
         tick(($urandom_range(63, 0) == 0), 20'(rv));
      end

      // Positive full-scale stress then recovery at zero
      tick(1'b1, '0);
      for (int i = 0; i < 2000; i++) tick(1'b0, 20'sh7FFFF);
      for (int i = 0; i < 64; i++)   tick(1'b0, '0);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         tick(1'b0, '0);
         ones += int'(pwm);
      end
      chk_range("fs_pos_recover", ones, 492, 532);

      // Negative full-scale stress then recovery at zero
      for (int i = 0; i < 1500; i++) tick(1'b0, 20'sh80000);
      for (int i = 0; i < 64; i++)   tick(1'b0, '0);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         tick(1'b0, '0);
         ones += int'(pwm);
      end
      chk_range("fs_neg_recover", ones, 492, 532);

      // Mid-stream reset returns to the zero-input start-up sequence
      for (int i = 0; i < 500; i++) tick(1'b0, 20'sh30000);
      tick(1'b1, 20'sh30000);
      chk("midreset_i1", longint'(dut.i1), 0);
      chk("midreset_i2", longint'(dut.i2), 0);
      chk("midreset_pwm", pwm, 0);
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, '0);
`ifndef DSM_DITHER_EN
         chk("midreset_seq", pwm, zseq[i]);
`endif
      end

`ifdef DSM_DITHER_EN
      // Dithered idle: mean near half, and not stuck in the period-4 tone
      tick(1'b1, '0);
      ones = 0;
      aper = 0;
      for (int i = 0; i < 4096; i++) begin
         tick(1'b0, '0);
         ones += int'(pwm);
         if (i >= 4 && hist[i % 4] != pwm) aper++;
         hist[i % 4] = pwm;
      end
      chk_range("dither_density", ones, 1966, 2130);
      chk_range("dither_aperiodic", aper, 1, 4096);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
